// File: rtl/sine_if.sv
// sine_if: angle/start request and sine/done result bundle for the CORDIC sine block
interface sine_if;
  logic [15:0] Angle_i;
  logic        Start_i;
  logic [15:0] Sine_o;
  logic        Done_o;
  modport master (output Angle_i, Start_i, input Sine_o, Done_o);
  modport slave (input Angle_i, Start_i, output Sine_o, Done_o);
endinterface

// File: rtl/sine.sv
// sine: iterative rotation-mode CORDIC, 16-bit binary angle in, Q1.14 sine out
module sine #(
  parameter int ITERATIONS = 16
) (
  input logic Clk_i,
  input logic Rst_i,
  sine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [13:0] ATAN [16] = '{14'd8192, 14'd4836, 14'd2555, 14'd1297, 14'd651, 14'd326, 14'd163, 14'd81,
                                        14'd41, 14'd20, 14'd10, 14'd5, 14'd3, 14'd1, 14'd1, 14'd0};
  localparam logic signed [19:0] X0 = 20'sd159189;
  state_t state_q, state_d;
  logic signed [19:0] x_q, x_d, y_q, y_d, x_n, y_n;
  logic signed [16:0] z_q, z_d, z_n, z0, atan;
  logic signed [20:0] y_r;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] sine_q, sine_d, sat;
  logic done_q, done_d;
  // quadrant fold, one micro-rotation, rounding/saturation and FSM next state
  always_comb begin
    z0 = (bus.Angle_i >= 16'h4000 && bus.Angle_i < 16'hC000) ? 17'sh08000 - $signed({1'b0, bus.Angle_i})
                                                              : $signed({bus.Angle_i[15], bus.Angle_i});
    atan = $signed({3'b000, ATAN[cnt_q]});
    x_n = z_q[16] ? x_q + (y_q >>> cnt_q) : x_q - (y_q >>> cnt_q);
    y_n = z_q[16] ? y_q - (x_q >>> cnt_q) : y_q + (x_q >>> cnt_q);
    z_n = z_q[16] ? z_q + atan : z_q - atan;
    y_r = ($signed({y_n[19], y_n}) + 21'sd8) >>> 4;
    sat = (y_r > 21'sd16384) ? 16'h4000 : (y_r < -21'sd16384) ? 16'hC000 : y_r[15:0];
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    cnt_d = cnt_q;
    sine_d = sine_q;
    done_d = done_q;
    if (state_q == RUN) begin
      x_d = x_n;
      y_d = y_n;
      z_d = z_n;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(ITERATIONS - 1)) begin
        sine_d = sat;
        done_d = 1'b1;
        state_d = DONE;
      end
    end else if (bus.Start_i) begin
      x_d = X0;
      y_d = '0;
      z_d = z0;
      cnt_d = '0;
      done_d = 1'b0;
      state_d = RUN;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      cnt_q <= '0;
      sine_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      cnt_q <= cnt_d;
      sine_q <= sine_d;
      done_q <= done_d;
    end
  end
  assign bus.Sine_o = sine_q;
  assign bus.Done_o = done_q;
endmodule

// File: tb/tb_sine.sv
// tb_sine: randomized and directed checks of the CORDIC sine against a reference model
module tb_sine;
  localparam int ITER = 16;
  logic Clk_i = 1'b0;
  logic Rst_i = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] prev;
  sine_if bus ();
  sine #(.ITERATIONS(ITER)) dut (.Clk_i(Clk_i), .Rst_i(Rst_i), .bus(bus));
  always #5 Clk_i = ~Clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a);
    int atab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
    longint x, y, z, t;
    longint d;
    x = 159189;
    y = 0;
    if (a >= 16'h4000 && a < 16'hC000) z = 32768 - longint'(a);
    else if (a >= 16'hC000) z = longint'(a) - 65536;
    else z = longint'(a);
    for (int i = 0; i < ITER; i++) begin
      d = (z >= 0) ? 1 : -1;
      t = x - d * (y >>> i);
      y = y + d * (x >>> i);
      x = t;
      z = z - d * atab[i];
    end
    t = (y + 8) >>> 4;
    if (t > 16384) t = 16384;
    if (t < -16384) t = -16384;
    return t[15:0];
  endfunction

  task automatic run(input logic [15:0] a, input int pulse_at, input logic [15:0] pa, output int lat);
    @(negedge Clk_i);
    bus.Angle_i = a;
    bus.Start_i = 1'b1;
    @(posedge Clk_i);
    #1;
    lat = 1;
    chk("done_drop", {31'd0, bus.Done_o}, 32'd0);
    chk("sine_hold", {16'd0, bus.Sine_o}, {16'd0, prev});
    while (!bus.Done_o && lat < 40) begin
      @(negedge Clk_i);
      bus.Start_i = (lat == pulse_at);
      if (lat == pulse_at) bus.Angle_i = pa;
      @(posedge Clk_i);
      #1;
      lat++;
    end
    bus.Start_i = 1'b0;
    chk("latency", lat, 17);
    chk("done_set", {31'd0, bus.Done_o}, 32'd1);
    chk("result", {16'd0, bus.Sine_o}, {16'd0, model(a)});
    prev = model(a);
  endtask

  task automatic near(input string tag, input logic [15:0] exp);
    int g, e, o;
    g = int'($signed(bus.Sine_o));
    e = int'($signed(exp));
    o = (g - e <= 2 && e - g <= 2) ? e : g;
    chk(tag, o, e);
  endtask

  initial begin
    int lat;
    int k;
    logic [15:0] a;
    logic [15:0] dir_a [7] = '{16'h2000, 16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h1555, 16'hA000};
    logic [15:0] dir_e [7] = '{16'h2D41, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 16'h2000, 16'hD2BF};
    bus.Angle_i = '0;
    bus.Start_i = 1'b0;
    prev = '0;
    repeat (2) @(posedge Clk_i);
    #1;
    chk("rst_sine", {16'd0, bus.Sine_o}, 32'd0);
    chk("rst_done", {31'd0, bus.Done_o}, 32'd0);
    @(negedge Clk_i);
    Rst_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(dir_a[i], 0, 16'h0, lat);
      near($sformatf("spec_%04h", dir_a[i]), dir_e[i]);
    end
    run(16'h1000, 5, 16'h7000, lat);
    @(negedge Clk_i);
    bus.Angle_i = 16'h3000;
    bus.Start_i = 1'b1;
    @(posedge Clk_i);
    @(negedge Clk_i);
    bus.Start_i = 1'b0;
    repeat (4) @(posedge Clk_i);
    @(negedge Clk_i);
    Rst_i = 1'b0;
    #1;
    chk("abort_sine", {16'd0, bus.Sine_o}, 32'd0);
    chk("abort_done", {31'd0, bus.Done_o}, 32'd0);
    @(posedge Clk_i);
    #1;
    chk("abort_hold", {31'd0, bus.Done_o}, 32'd0);
    @(negedge Clk_i);
    Rst_i = 1'b1;
    prev = '0;
    run(16'h3000, 0, 16'h0, lat);
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      run(a, (n % 3 == 0) ? int'($urandom_range(2, 15)) : 0, 16'($urandom), lat);
      k = int'($urandom_range(0, 3));
      repeat (k) @(posedge Clk_i);
      #1;
      chk("done_stable", {31'd0, bus.Done_o}, 32'd1);
      chk("sine_stable", {16'd0, bus.Sine_o}, {16'd0, prev});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
